// File: rtl/dcache_port_responder.sv
// dcache_port_responder
// Responder end of a data-cache request port. It grants a request, takes the
// tag one cycle later, and returns load data after LATENCY cycles from a
// local 64-bit word memory. Stores write only the byte lanes selected by be.
// The request and response structs are flattened into individual ports:
// req_* fields come from the initiator and rsp_* fields go back to it.
// Optional feature: define DCACHE_RESP_RANDSTALL_EN to add LFSR-driven
// grant back-pressure (16-bit Fibonacci LFSR, taps 16,14,13,11, seed 0xACE1).
module dcache_port_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int INDEX_W = 12,
    parameter int TAG_W   = 44
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] req_address_index,
    input  logic [TAG_W-1:0]   req_address_tag,
    input  logic [63:0]        req_data_wdata,
    input  logic               req_data_req,
    input  logic               req_data_we,
    input  logic [7:0]         req_data_be,
    input  logic [1:0]         req_data_size,
    input  logic               req_kill_req,
    input  logic               req_tag_valid,
    output logic               rsp_data_gnt,
    output logic               rsp_data_rvalid,
    output logic [63:0]        rsp_data_rdata,
    output logic [31:0]        loads_served_o
);

    localparam int AW     = $clog2(DEPTH);
    localparam int ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e             state_r, state_n_s;
    logic [3:0]         cnt_r, cnt_n_s;
    logic [INDEX_W-1:0] idx_r;
    logic               we_r;
    logic [63:0]        wdata_r;
    logic [7:0]         be_r;
    logic [AW-1:0]      word_r;
    logic [63:0]        mem_r [DEPTH];
    logic [31:0]        served_r;

    logic               stall_s;
    logic               gnt_s;
    logic               rvalid_s;
    logic               accept_s;
    logic               load_commit_s;
    logic               store_commit_s;
    logic [ADDR_W-1:0]  addr_s;
    logic [AW-1:0]      word_s;
    logic               unused_s;

    // The tag arrives in the cycle after the grant; the word index comes from
    // the full byte address, so bits above the memory size simply wrap.
    assign addr_s   = {req_address_tag, idx_r};
    assign word_s   = addr_s[3 +: AW];
    assign unused_s = ^{req_data_size, addr_s};

`ifdef DCACHE_RESP_RANDSTALL_EN
    logic [15:0] lfsr_r;
    logic        lfsr_fb_s;

    assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    assign stall_s   = (lfsr_r[1:0] == 2'b00);

    // Free-running stall pattern generator, restarted from a fixed seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
        end
    end
`else
    assign stall_s = 1'b0;
`endif

    // Next-state and handshake decode; reset suppresses grant and rvalid.
    always_comb begin
        state_n_s      = state_r;
        cnt_n_s        = cnt_r;
        gnt_s          = 1'b0;
        rvalid_s       = 1'b0;
        accept_s       = 1'b0;
        load_commit_s  = 1'b0;
        store_commit_s = 1'b0;
        if (rst) begin
            state_n_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_data_req && !stall_s) begin
                        gnt_s     = 1'b1;
                        accept_s  = 1'b1;
                        state_n_s = ST_TAG;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_TAG: begin
                    if (req_kill_req) begin
                        state_n_s = ST_IDLE;
                    end else if (req_tag_valid) begin
                        if (we_r) begin
                            store_commit_s = 1'b1;
                            state_n_s      = ST_IDLE;
                        end else begin
                            load_commit_s = 1'b1;
                            cnt_n_s       = 4'(LATENCY - 1);
                            state_n_s     = ST_WAIT;
                        end
                    end else begin
                        state_n_s = ST_TAG;
                    end
                end
                ST_WAIT: begin
                    if (req_kill_req) begin
                        state_n_s = ST_IDLE;
                    end else if (cnt_r == 4'd0) begin
                        rvalid_s = 1'b1;
                        // The return cycle doubles as an accept slot so loads can stream.
                        if (req_data_req && !stall_s) begin
                            gnt_s     = 1'b1;
                            accept_s  = 1'b1;
                            state_n_s = ST_TAG;
                        end else begin
                            state_n_s = ST_IDLE;
                        end
                    end else begin
                        cnt_n_s = cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_n_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    // Capture the request fields at grant and the word index at tag time.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r   <= '0;
            we_r    <= 1'b0;
            wdata_r <= 64'd0;
            be_r    <= 8'd0;
            word_r  <= '0;
        end else begin
            if (accept_s) begin
                idx_r   <= req_address_index;
                we_r    <= req_data_we;
                wdata_r <= req_data_wdata;
                be_r    <= req_data_be;
            end
            if (load_commit_s) begin
                word_r <= word_s;
            end
        end
    end

    // Word memory: each word resets to its own index; stores are byte-masked.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 64'(i);
            end
        end else if (store_commit_s) begin
            for (int b = 0; b < 8; b++) begin
                if (be_r[b]) begin
                    mem_r[word_s][8*b +: 8] <= wdata_r[8*b +: 8];
                end
            end
        end
    end

    // Saturating count of returned loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            served_r <= 32'd0;
        end else if (rvalid_s && (served_r != 32'hFFFF_FFFF)) begin
            served_r <= served_r + 32'd1;
        end
    end

    assign rsp_data_gnt    = gnt_s;
    assign rsp_data_rvalid = rvalid_s;
    assign rsp_data_rdata  = rvalid_s ? mem_r[word_r] : 64'd0;
    assign loads_served_o  = served_r;

endmodule

// File: tb/tb_dcache_port_responder.sv
// Self-checking bench for dcache_port_responder (DEPTH=256, LATENCY=2).
// A transaction-level model (pending phase plus absolute return cycle) is
// compared with the DUT at every falling edge; directed scenarios add
// hand-computed literal checks on returned data, latency and load count.
module tb_dcache_port_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] req_address_index = 12'd0;
    logic [43:0] req_address_tag = 44'd0;
    logic [63:0] req_data_wdata = 64'd0;
    logic        req_data_req = 1'b0;
    logic        req_data_we = 1'b0;
    logic [7:0]  req_data_be = 8'd0;
    logic [1:0]  req_data_size = 2'd3;
    logic        req_kill_req = 1'b0;
    logic        req_tag_valid = 1'b0;
    logic        rsp_data_gnt;
    logic        rsp_data_rvalid;
    logic [63:0] rsp_data_rdata;
    logic [31:0] loads_served_o;

    dcache_port_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_address_index (req_address_index),
        .req_address_tag   (req_address_tag),
        .req_data_wdata    (req_data_wdata),
        .req_data_req      (req_data_req),
        .req_data_we       (req_data_we),
        .req_data_be       (req_data_be),
        .req_data_size     (req_data_size),
        .req_kill_req      (req_kill_req),
        .req_tag_valid     (req_tag_valid),
        .rsp_data_gnt      (rsp_data_gnt),
        .rsp_data_rvalid   (rsp_data_rvalid),
        .rsp_data_rdata    (rsp_data_rdata),
        .loads_served_o    (loads_served_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model state
    logic [63:0] mem_m [DEPTH];
    int          pend_m = 0;      // 0 none, 1 granted awaiting tag, 2 load awaiting data
    int          due_m  = 0;      // absolute cycle of the expected rvalid
    logic [11:0] idx_m;
    logic        we_m;
    logic [63:0] wd_m;
    logic [7:0]  be_m;
    int          word_m;
    logic [31:0] served_m = 32'd0;
    logic [15:0] lfsr_m = 16'hACE1;

    // Observation logs
    int          gnt_log[$];
    int          rv_cyc[$];
    logic [63:0] rv_data[$];

    int          loads_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 64'(i);
        pend_m   = 0;
        served_m = 32'd0;
        lfsr_m   = 16'hACE1;
    endtask

    task automatic compare_step();
        logic        stall_m, exp_rv, exp_gnt;
        logic [63:0] exp_rd;
        logic [55:0] full;
        int          w;
`ifdef DCACHE_RESP_RANDSTALL_EN
        stall_m = (lfsr_m[1:0] == 2'b00);
`else
        stall_m = 1'b0;
`endif
        exp_rv  = !rst && pend_m == 2 && cyc == due_m && !req_kill_req;
        exp_gnt = !rst && req_data_req && !stall_m && (pend_m == 0 || exp_rv);
        exp_rd  = exp_rv ? mem_m[word_m] : 64'd0;
        chk("gnt", 64'(rsp_data_gnt), 64'(exp_gnt));
        chk("rvalid", 64'(rsp_data_rvalid), 64'(exp_rv));
        chk("rdata", rsp_data_rdata, exp_rd);
        chk("loads_served", 64'(loads_served_o), 64'(served_m));
        if (rsp_data_gnt) gnt_log.push_back(cyc);
        if (rsp_data_rvalid) begin
            rv_cyc.push_back(cyc);
            rv_data.push_back(rsp_data_rdata);
        end
        // Advance the model to what the coming rising edge commits.
        if (rst) begin
            model_reset();
        end else begin
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
            if (exp_rv && served_m != 32'hFFFF_FFFF) served_m = served_m + 32'd1;
            if (pend_m == 1) begin
                if (req_kill_req) begin
                    pend_m = 0;
                end else if (req_tag_valid) begin
                    full = {req_address_tag, idx_m};
                    w    = int'(full[10:3]);
                    if (we_m) begin
                        for (int b = 0; b < 8; b++)
                            if (be_m[b]) mem_m[w][8*b +: 8] = wd_m[8*b +: 8];
                        pend_m = 0;
                    end else begin
                        word_m = w;
                        due_m  = cyc + LATENCY;
                        pend_m = 2;
                    end
                end
            end else if (pend_m == 2) begin
                if (req_kill_req || exp_rv) pend_m = 0;
            end
            if (exp_gnt) begin
                pend_m = 1;
                idx_m  = req_address_index;
                we_m   = req_data_we;
                wd_m   = req_data_wdata;
                be_m   = req_data_be;
            end
        end
        cyc++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Request, wait for grant (bounded), then present the tag.
    task automatic issue(input logic [55:0] a, input logic we, input logic [63:0] wd,
                         input logic [7:0] be, input int tag_delay, input logic kill_tag);
        logic got;
        req_data_req      = 1'b1;
        req_address_index = a[11:0];
        req_data_we       = we;
        req_data_wdata    = wd;
        req_data_be       = be;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = rsp_data_gnt;
        end
        if (!got) chk("grant_timeout", 64'd0, 64'd1);
        step(1);
        req_data_req = 1'b0;
        req_kill_req = 1'b0;
        if (tag_delay > 0) step(tag_delay);
        req_tag_valid   = 1'b1;
        req_address_tag = a[55:12];
        req_kill_req    = kill_tag;
        step(1);
        req_tag_valid = 1'b0;
        req_kill_req  = 1'b0;
    endtask

    task automatic load_chk(input string name, input logic [55:0] a, input logic [63:0] exp);
        int n0;
        n0 = rv_data.size();
        issue(a, 1'b0, 64'd0, 8'd0, 0, 1'b0);
        step(2);
        loads_done++;
        chk({name, "_count"}, 64'(rv_data.size()), 64'(n0 + 1));
        if (rv_data.size() > n0) chk({name, "_data"}, rv_data[$], exp);
        chk({name, "_served"}, 64'(loads_served_o), 64'(loads_done));
    endtask

    task automatic stimulus();
        int n0, kc;
        step(3);
        rst = 1'b0;
        req_data_req = 1'b0;
        step(1);
        chk("reset_served", 64'(loads_served_o), 64'd0);
        chk("reset_no_grant", 64'(gnt_log.size()), 64'd0);

        // Basic load: word 8, gnt G, rvalid G+3
        load_chk("load40", 56'h40, 64'h8);
        if (rv_cyc.size() > 0 && gnt_log.size() > 0)
            chk("load40_latency", 64'(rv_cyc[$] - gnt_log[$]), 64'd3);

        // Byte-masked store then load
        issue(56'h40, 1'b1, 64'hDEAD_BEEF_0000_1111, 8'h0F, 0, 1'b0);
        step(1);
        load_chk("st_ld40", 56'h40, 64'h0000_0000_0000_1111);

        // Back-to-back loads with data_req held high
        n0 = rv_data.size();
        req_data_req = 1'b1; req_data_we = 1'b0; req_address_index = 12'h000;
        step(1);
        req_tag_valid = 1'b1; req_address_tag = 44'd0; req_address_index = 12'h008;
        step(1);
        req_tag_valid = 1'b0;
        step(2);
        req_data_req = 1'b0; req_tag_valid = 1'b1;
        step(1);
        req_tag_valid = 1'b0;
        step(3);
        loads_done += 2;
        chk("b2b_count", 64'(rv_data.size()), 64'(n0 + 2));
        if (rv_data.size() >= n0 + 2) begin
            chk("b2b_data0", rv_data[n0], 64'd0);
            chk("b2b_data1", rv_data[n0 + 1], 64'd1);
            chk("b2b_rv_spacing", 64'(rv_cyc[n0 + 1] - rv_cyc[n0]), 64'd3);
            chk("b2b_gnt_spacing", 64'(gnt_log[$] - gnt_log[gnt_log.size() - 2]), 64'd3);
        end

        // Kill in WAIT: no rvalid, next request granted the following cycle
        n0 = rv_data.size();
        issue(56'h10, 1'b0, 64'd0, 8'd0, 0, 1'b0);
        req_kill_req = 1'b1;
        kc = cyc;
        step(1);
        req_kill_req = 1'b0;
        chk("kill_no_rvalid", 64'(rv_data.size()), 64'(n0));
        chk("kill_served", 64'(loads_served_o), 64'(loads_done));
        load_chk("after_kill", 56'h18, 64'd3);
        chk("after_kill_gnt_cycle", 64'(gnt_log[$]), 64'(kc + 1));

        // Kill and tag_valid together: kill wins
        n0 = rv_data.size();
        issue(56'h20, 1'b0, 64'd0, 8'd0, 0, 1'b1);
        step(3);
        chk("kill_tag_no_rvalid", 64'(rv_data.size()), 64'(n0));

        // Tag arrives late: responder waits in TAG
        n0 = rv_data.size();
        issue(56'h28, 1'b0, 64'd0, 8'd0, 2, 1'b0);
        step(2);
        loads_done++;
        if (rv_data.size() > n0) chk("late_tag_data", rv_data[$], 64'd5);

        // Address wrap and ignored high tag bits
        load_chk("wrap800", 56'h800, 64'd0);
        load_chk("hightag", 56'h10_0000_0048, 64'd9);

        // kill_req in IDLE is ignored
        req_kill_req = 1'b1;
        load_chk("idle_kill", 56'h30, 64'd6);

        // Sparse byte enables, and a wrapped full-word store
        issue(56'h38, 1'b1, 64'h1122_3344_5566_7788, 8'hA5, 0, 1'b0);
        load_chk("be_a5", 56'h38, 64'h1100_3300_0066_0088);
        issue(56'h808, 1'b1, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, 1'b0);
        load_chk("wrap_store", 56'h8, 64'hCAFE_F00D_1234_5678);

        // Reset with a load in flight: dropped, memory and count restored
        n0 = rv_data.size();
        issue(56'h40, 1'b0, 64'd0, 8'd0, 0, 1'b0);
        rst = 1'b1;
        req_data_req = 1'b1;
        step(2);
        rst = 1'b0;
        req_data_req = 1'b0;
        step(3);
        chk("rst_drop", 64'(rv_data.size()), 64'(n0));
        chk("rst_served", 64'(loads_served_o), 64'd0);
        loads_done = 0;
        load_chk("post_rst", 56'h40, 64'h8);

`ifdef DCACHE_RESP_RANDSTALL_EN
        n0 = rv_data.size();
        for (int i = 0; i < 100; i++) begin
            issue(56'(i * 8), 1'b0, 64'd0, 8'd0, 0, 1'b0);
            step(1);
        end
        step(3);
        chk("stall_count", 64'(rv_data.size()), 64'(n0 + 100));
        if (rv_data.size() > n0) chk("stall_last", rv_data[$], 64'd99);
`endif
        step(2);
    endtask

    initial begin
        model_reset();
        fork
            forever begin
                @(negedge clk);
                compare_step();
            end
            stimulus();
            begin
                #2000000;
                chk("global_timeout", 64'd0, 64'd1);
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
